// File: rtl/udp_cam_pkg.sv
// Shared types and constants for the camera UDP payload path (send and receive sides).
package udp_cam_pkg;

    localparam int WORD_BYTES  = 16;
    localparam int HEAD_BYTES  = 2;
    localparam int STRETCH_LEN = 4;

    typedef enum logic [2:0] {
        IDLE,
        HEAD_HI,
        HEAD_LO,
        DATA,
        DONE
    } state_t;

    typedef struct packed {
        logic        last;
        logic [14:0] rank;
    } hdr_t;

endpackage

// File: rtl/udp_128bit_recv_if.sv
// Bus between the UDP receive stack / frame assembler (master) and udp_128bit_recv (slave).
interface udp_128bit_recv_if;

    logic         i_en;
    logic         i_udp_rx_sop;
    logic         i_udp_rx_de;
    logic [7:0]   i_udp_rx_data;
    logic [15:0]  i_udp_rx_len;

    logic [127:0] o_ddr3_wrdata;
    logic         o_ddr3_wr_req;
    logic         o_last_frame_flag;
    logic [14:0]  o_mjpeg_frame_rank;
    logic [15:0]  o_jpeg_len;
    logic         o_frame_done;
    logic         o_err;
    logic         o_busy;

    modport master (
        output i_en, i_udp_rx_sop, i_udp_rx_de, i_udp_rx_data, i_udp_rx_len,
        input  o_ddr3_wrdata, o_ddr3_wr_req, o_last_frame_flag, o_mjpeg_frame_rank,
        input  o_jpeg_len, o_frame_done, o_err, o_busy
    );

    modport slave (
        input  i_en, i_udp_rx_sop, i_udp_rx_de, i_udp_rx_data, i_udp_rx_len,
        output o_ddr3_wrdata, o_ddr3_wr_req, o_last_frame_flag, o_mjpeg_frame_rank,
        output o_jpeg_len, o_frame_done, o_err, o_busy
    );

endinterface

// File: rtl/udp_pulse_stretch.sv
// Widens a 1-cycle pulse to LEN cycles (pulse OR its LEN-1 delayed copies) for slower-domain capture.
module udp_pulse_stretch
    import udp_cam_pkg::*;
#(
    parameter int LEN = STRETCH_LEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pulse_in,
    output logic pulse_out
);

    logic [LEN-1:1] stage_reg;
    logic [LEN-1:0] tap;

    assign tap[0]       = pulse_in;
    assign tap[LEN-1:1] = stage_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= tap[LEN-2:0];
        end
    end

    assign pulse_out = |tap;

endmodule

// File: rtl/udp_128bit_recv.sv
// Strips the 2-byte frame header from UDP payload and packs JPEG bytes MSB-first into 128-bit words.
// Optional: UDP_RECV_PULSE_STRETCH_EN widens wr_req and frame_done to STRETCH_LEN cycles.
module udp_128bit_recv
    import udp_cam_pkg::*;
(
    input  logic             i_udp_clk50m,
    input  logic             i_rst_n,
    udp_128bit_recv_if.slave bus
);

    localparam int LANE_W = $clog2(WORD_BYTES);
    localparam int WORD_W = WORD_BYTES * 8;

    state_t              state_reg, state_next;
    hdr_t                hdr_reg;
    logic [15:0]         jpeg_len_reg;
    logic [15:0]         data_cnt_reg;
    logic [LANE_W-1:0]   lane_cnt_reg;
    logic [WORD_W-1:0]   pack_reg;
    logic [WORD_W-1:0]   pack_wr;
    logic [WORD_W-1:0]   wrdata_reg;
    logic                wr_req_reg, done_reg, err_reg, busy_reg;

    logic in_pkt, len_ok, last_byte;
    logic load_len, clr_pkt, hi_we, lo_we, data_we, emit, err_pulse;

    assign in_pkt    = (state_reg == HEAD_HI) || (state_reg == HEAD_LO) || (state_reg == DATA);
    assign len_ok    = bus.i_udp_rx_len >= 16'(HEAD_BYTES);
    // jpeg_len is at least 1 whenever DATA is reachable, so the subtraction cannot wrap
    assign last_byte = data_cnt_reg == (jpeg_len_reg - 16'd1);

    // Pack buffer with the incoming byte merged at lane (15 - lane_cnt); lane 15 sits in [127:120]
    genvar gi;
    generate
        for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
            assign pack_wr[gi*8 +: 8] = (lane_cnt_reg == LANE_W'(WORD_BYTES - 1 - gi))
                                        ? bus.i_udp_rx_data : pack_reg[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge i_udp_clk50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        load_len   = 1'b0;
        clr_pkt    = 1'b0;
        hi_we      = 1'b0;
        lo_we      = 1'b0;
        data_we    = 1'b0;
        emit       = 1'b0;
        err_pulse  = 1'b0;
        if (bus.i_udp_rx_sop) begin
            // Any SOP drops the partial word; a mid-packet SOP or a runt length is an error
            clr_pkt    = 1'b1;
            err_pulse  = in_pkt || (bus.i_en && !len_ok);
            state_next = IDLE;
            if (bus.i_en && len_ok) begin
                load_len = 1'b1;
                if (bus.i_udp_rx_de) begin
                    hi_we      = 1'b1;
                    state_next = HEAD_LO;
                end else begin
                    state_next = HEAD_HI;
                end
            end
        end else begin
            case (state_reg)
                HEAD_HI: begin
                    if (bus.i_udp_rx_de) begin
                        hi_we      = 1'b1;
                        state_next = HEAD_LO;
                    end
                end
                HEAD_LO: begin
                    if (bus.i_udp_rx_de) begin
                        lo_we      = 1'b1;
                        state_next = (jpeg_len_reg == 16'd0) ? DONE : DATA;
                    end
                end
                DATA: begin
                    if (bus.i_udp_rx_de) begin
                        data_we = 1'b1;
                        emit    = (lane_cnt_reg == LANE_W'(WORD_BYTES - 1)) || last_byte;
                        if (last_byte) begin
                            state_next = DONE;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_udp_clk50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hdr_reg      <= '0;
            jpeg_len_reg <= '0;
            data_cnt_reg <= '0;
            lane_cnt_reg <= '0;
            pack_reg     <= '0;
            wrdata_reg   <= '0;
            wr_req_reg   <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            wr_req_reg <= emit;
            err_reg    <= err_pulse;
            done_reg   <= (state_reg == DONE);
            busy_reg   <= (state_next != IDLE);
            if (load_len) begin
                jpeg_len_reg <= bus.i_udp_rx_len - 16'(HEAD_BYTES);
            end
            if (hi_we) begin
                hdr_reg.last       <= bus.i_udp_rx_data[7];
                hdr_reg.rank[14:8] <= bus.i_udp_rx_data[6:0];
            end
            if (lo_we) begin
                hdr_reg.rank[7:0] <= bus.i_udp_rx_data;
            end
            if (clr_pkt) begin
                pack_reg     <= '0;
                lane_cnt_reg <= '0;
                data_cnt_reg <= '0;
            end else if (data_we) begin
                lane_cnt_reg <= lane_cnt_reg + LANE_W'(1);
                data_cnt_reg <= data_cnt_reg + 16'd1;
                if (emit) begin
                    wrdata_reg <= pack_wr;
                    pack_reg   <= '0;
                end else begin
                    pack_reg   <= pack_wr;
                end
            end
        end
    end

    logic wr_req_out, done_out;

`ifdef UDP_RECV_PULSE_STRETCH_EN
    udp_pulse_stretch #(.LEN(STRETCH_LEN)) u_wr_req_stretch (
        .clk       (i_udp_clk50m),
        .rst_n     (i_rst_n),
        .pulse_in  (wr_req_reg),
        .pulse_out (wr_req_out)
    );

    udp_pulse_stretch #(.LEN(STRETCH_LEN)) u_done_stretch (
        .clk       (i_udp_clk50m),
        .rst_n     (i_rst_n),
        .pulse_in  (done_reg),
        .pulse_out (done_out)
    );
`else
    assign wr_req_out = wr_req_reg;
    assign done_out   = done_reg;
`endif

    assign bus.o_ddr3_wrdata      = wrdata_reg;
    assign bus.o_ddr3_wr_req      = wr_req_out;
    assign bus.o_last_frame_flag  = hdr_reg.last;
    assign bus.o_mjpeg_frame_rank = hdr_reg.rank;
    assign bus.o_jpeg_len         = jpeg_len_reg;
    assign bus.o_frame_done       = done_out;
    assign bus.o_err              = err_reg;
    assign bus.o_busy             = busy_reg;

endmodule

// File: tb/tb_udp_128bit_recv.sv
// Scoreboard bench for udp_128bit_recv: packet-level model fills queues, a negedge monitor checks outputs.
module tb_udp_128bit_recv;
    import udp_cam_pkg::*;

`ifdef UDP_RECV_PULSE_STRETCH_EN
    localparam int PW      = STRETCH_LEN;
    localparam int GAP_MIN = 20;
`else
    localparam int PW      = 1;
    localparam int GAP_MIN = 0;
`endif

    typedef struct {
        logic [127:0] word;
        int           cyc;
    } wr_exp_t;

    typedef struct {
        logic        flag;
        logic [14:0] rank;
        int          cyc;
    } done_exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    udp_128bit_recv_if bus();

    udp_128bit_recv dut (
        .i_udp_clk50m (clk),
        .i_rst_n      (rst_n),
        .bus          (bus)
    );

    always #10 clk = ~clk;

    int checks    = 0;
    int failures  = 0;
    int cycle_cnt = 0;
    int err_exp   = 0;
    int err_seen  = 0;
    bit in_pkt    = 1'b0;
    bit no_sop_de = 1'b0;

    wr_exp_t    wr_q[$];
    done_exp_t  done_q[$];
    logic [7:0] data_q[$];

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string name);
        check({name, "_wrdata"}, bus.o_ddr3_wrdata, 128'd0);
        check({name, "_ctl"}, 128'({bus.o_ddr3_wr_req, bus.o_last_frame_flag, bus.o_mjpeg_frame_rank,
                                    bus.o_jpeg_len, bus.o_frame_done, bus.o_err, bus.o_busy}), 128'd0);
    endtask

    // Expected word for JPEG byte index d: the 16-byte group holding d, bytes up to d, zeros after
    function automatic logic [127:0] word_of(input logic [7:0] pay[$], input int d);
        logic [127:0] w;
        int base;
        w    = '0;
        base = d - (d % 16);
        for (int k = base; k <= d; k++) w[127 - 8*(k - base) -: 8] = pay[k + 2];
        return w;
    endfunction

    // Sends SOP plus the first n_send payload bytes (header first) of a packet of length len
    task automatic send_pkt(input int len, input logic [15:0] hdr, input bit en, input int n_send,
                            input int space, input bit sop_de);
        logic [7:0] pay[$];
        bit acc;
        int jl;
        int d;
        wr_exp_t   we;
        done_exp_t dx;
        pay.delete();
        pay.push_back(hdr[15:8]);
        pay.push_back(hdr[7:0]);
        foreach (data_q[k]) pay.push_back(data_q[k]);
        acc = en && (len >= 2);
        jl  = len - 2;
        if (in_pkt || (en && len < 2)) err_exp++;
        in_pkt = acc;
        bus.i_en         = en;
        bus.i_udp_rx_len = 16'(len);
        bus.i_udp_rx_sop = 1'b1;
        if (!(sop_de && n_send > 0 && !no_sop_de)) begin
            tick();
            bus.i_udp_rx_sop = 1'b0;
            check("busy_after_sop", 128'(bus.o_busy), 128'(acc));
            if (acc) check("jpeg_len", 128'(bus.o_jpeg_len), 128'(jl));
        end
        for (int i = 0; i < n_send; i++) begin
            bus.i_udp_rx_de   = 1'b1;
            bus.i_udp_rx_data = pay[i];
            tick();
            if (bus.i_udp_rx_sop) begin
                check("busy_after_sop", 128'(bus.o_busy), 128'(acc));
                if (acc) check("jpeg_len", 128'(bus.o_jpeg_len), 128'(jl));
            end
            bus.i_udp_rx_sop = 1'b0;
            bus.i_udp_rx_de  = 1'b0;
            if (acc) begin
                if (i == 1 && jl == 0) begin
                    dx.flag = hdr[15]; dx.rank = hdr[14:0]; dx.cyc = cycle_cnt + 1;
                    done_q.push_back(dx);
                end
                if (i >= 2) begin
                    d = i - 2;
                    if (d % 16 == 15 || d == jl - 1) begin
                        we.word = word_of(pay, d); we.cyc = cycle_cnt;
                        wr_q.push_back(we);
                    end
                    if (d == jl - 1) begin
                        dx.flag = hdr[15]; dx.rank = hdr[14:0]; dx.cyc = cycle_cnt + 1;
                        done_q.push_back(dx);
                    end
                end
            end
            if (i + 1 < n_send) repeat (space) tick();
        end
        if (acc && n_send == len) in_pkt = 1'b0;
        no_sop_de = 1'b0;
    endtask

    // Idle gap; junk bytes outside a packet must be ignored by the DUT
    task automatic gap(input int n);
        if (n == 0) no_sop_de = 1'b1;
        repeat (n) begin
            bus.i_udp_rx_de   = !in_pkt && ($urandom_range(0, 1) == 1);
            bus.i_udp_rx_data = 8'($urandom);
            tick();
        end
        bus.i_udp_rx_de = 1'b0;
    endtask

    task automatic fill_data(input int n);
        data_q.delete();
        for (int k = 0; k < n; k++) data_q.push_back(8'($urandom));
    endtask

    initial begin : monitor
        wr_exp_t   we;
        done_exp_t dx;
        logic wr_p, dn_p, er_p;
        int   wr_w, dn_w, er_w;
        wr_p = 1'b0; dn_p = 1'b0; er_p = 1'b0;
        wr_w = 0;    dn_w = 0;    er_w = 0;
        forever begin
            @(negedge clk);
            if (bus.o_ddr3_wr_req && !wr_p) begin
                if (wr_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL wr_unexpected actual=%h required=none", bus.o_ddr3_wrdata);
                end else begin
                    we = wr_q.pop_front();
                    check("wr_data", bus.o_ddr3_wrdata, we.word);
                    check("wr_cycle", 128'(cycle_cnt), 128'(we.cyc));
                end
            end
            if (bus.o_ddr3_wr_req) wr_w++;
            else if (wr_p) begin check("wr_width", 128'(wr_w), 128'(PW)); wr_w = 0; end
            if (bus.o_frame_done && !dn_p) begin
                if (done_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL done_unexpected actual=1 required=0 at cycle %0d", cycle_cnt);
                end else begin
                    dx = done_q.pop_front();
                    check("done_flag", 128'(bus.o_last_frame_flag), 128'(dx.flag));
                    check("done_rank", 128'(bus.o_mjpeg_frame_rank), 128'(dx.rank));
                    check("done_cycle", 128'(cycle_cnt), 128'(dx.cyc));
                end
            end
            if (bus.o_frame_done) dn_w++;
            else if (dn_p) begin check("done_width", 128'(dn_w), 128'(PW)); dn_w = 0; end
            if (bus.o_err && !er_p) err_seen++;
            if (bus.o_err) er_w++;
            else if (er_p) begin check("err_width", 128'(er_w), 128'd1); er_w = 0; end
            wr_p = bus.o_ddr3_wr_req;
            dn_p = bus.o_frame_done;
            er_p = bus.o_err;
        end
    end

    initial begin : watchdog
        #10_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int len, n_send;
        bus.i_en = 1'b0; bus.i_udp_rx_sop = 1'b0; bus.i_udp_rx_de = 1'b0;
        bus.i_udp_rx_data = 8'd0; bus.i_udp_rx_len = 16'd0;
        repeat (3) tick();
        check_zero("reset_state");
        rst_n = 1'b1;
        repeat (2) tick();

        // Two full words, header 0x8005, one byte every 4 cycles
        data_q.delete();
        for (int k = 0; k < 32; k++) data_q.push_back(8'(k));
        send_pkt(34, 16'h8005, 1'b1, 34, 3, 1'b0);
        gap(GAP_MIN + 4);
        check("s1_flag", 128'(bus.o_last_frame_flag), 128'd1);
        check("s1_rank", 128'(bus.o_mjpeg_frame_rank), 128'd5);
        check("s1_jpeg_len", 128'(bus.o_jpeg_len), 128'd32);
        check("s1_last_word", bus.o_ddr3_wrdata, 128'h101112131415161718191A1B1C1D1E1F);

        // Partial final word
        data_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        send_pkt(7, 16'h0003, 1'b1, 7, 1, 1'b1);
        gap(GAP_MIN + 4);
        check("s2_word", bus.o_ddr3_wrdata, {40'hAABBCCDDEE, 88'd0});
        check("s2_rank", 128'(bus.o_mjpeg_frame_rank), 128'd3);
        check("s2_flag", 128'(bus.o_last_frame_flag), 128'd0);

        // Header-only packet
        data_q.delete();
        send_pkt(2, 16'h7FFF, 1'b1, 2, 0, 1'b1);
        gap(GAP_MIN + 4);
        check("s3_jpeg_len", 128'(bus.o_jpeg_len), 128'd0);

        // Runt packet, then a disabled packet
        send_pkt(1, 16'h1234, 1'b1, 1, 0, 1'b1);
        gap(GAP_MIN + 4);
        fill_data(18);
        send_pkt(20, 16'h4321, 1'b0, 20, 0, 1'b1);
        gap(GAP_MIN + 4);
        check("s5_busy", 128'(bus.o_busy), 128'd0);

        // Abort after 10 bytes, second packet must decode
        fill_data(18);
        send_pkt(20, 16'h0101, 1'b1, 10, 1, 1'b1);
        fill_data(18);
        send_pkt(20, 16'h8202, 1'b1, 20, 1, 1'b0);
        gap(GAP_MIN + 4);

        // Asynchronous reset in the middle of DATA
        fill_data(38);
        send_pkt(40, 16'h9999, 1'b1, 7, 2, 1'b1);
        #5 rst_n = 1'b0;
        #1 check_zero("mid_reset");
        in_pkt = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        fill_data(22);
        send_pkt(24, 16'h0A0B, 1'b1, 24, 0, 1'b1);
        gap(GAP_MIN + 4);

        // Randomized traffic
        for (int p = 0; p < 30; p++) begin
            if ($urandom_range(0, 9) == 0) len = $urandom_range(0, 1);
            else                           len = $urandom_range(2, 60);
            n_send = len;
            if (len >= 2 && $urandom_range(0, 6) == 0) n_send = $urandom_range(0, len - 1);
            fill_data((len >= 2) ? len - 2 : 0);
            send_pkt(len, 16'($urandom), ($urandom_range(0, 9) != 0), n_send,
                     $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            gap(GAP_MIN + $urandom_range(0, 3));
        end

        gap(30);
        check("wr_queue_drained", 128'(wr_q.size()), 128'd0);
        check("done_queue_drained", 128'(done_q.size()), 128'd0);
        check("err_count", 128'(err_seen), 128'(err_exp));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
